// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and receiver FSM state encoding.
// Used by the receiver, the transmitter and the multi-port collector.
package uart_pkg;
    localparam int DATA_W   = 8;
    localparam int BAUD_W   = 16;
    localparam int MIN_BAUD = 4;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value should match the input's idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;
endmodule

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver with mid-bit sampling, start-glitch rejection, frame-error
// pulse, sticky overrun and a one-byte holding register drained by i_read.
module uart_rx_port
    import uart_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [BAUD_W-1:0] i_baud,
    input  logic              i_rx,
    input  logic              i_read,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_D,
    output logic              o_ferr,
    output logic              o_overrun
);
    logic              rx_s;
    rx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] cnt_q, cnt_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BAUD_W-1:0] baud_in;
    logic [2:0]        bitidx_q, bitidx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ready_q, ready_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic              tick;
    logic              deliver;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (rx_s)
    );

    assign baud_in = (i_baud < BAUD_W'(MIN_BAUD)) ? BAUD_W'(MIN_BAUD) : i_baud;
    assign tick    = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = tick ? cnt_q : cnt_q - BAUD_W'(1);
        baud_d   = baud_q;
        bitidx_d = bitidx_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        ready_d  = ready_q;
        ovr_d    = ovr_q;
        ferr_d   = 1'b0;
        deliver  = 1'b0;

        case (state_q)
            RX_IDLE: begin
                // Half-period wait lands the start-bit check mid-bit.
                if (!rx_s) begin
                    state_d = RX_START;
                    baud_d  = baud_in;
                    cnt_d   = (baud_in >> 1) - BAUD_W'(1);
                end
            end
            RX_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_d  = RX_DATA;
                        cnt_d    = baud_q - BAUD_W'(1);
                        bitidx_d = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    shreg_d  = {rx_s, shreg_q[DATA_W-1:1]};
                    cnt_d    = baud_q - BAUD_W'(1);
                    bitidx_d = bitidx_q + 3'd1;
                    if (bitidx_q == 3'(DATA_W - 1)) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase

        // A read in the delivery cycle frees the slot for the new byte.
        if (deliver) begin
            if (!ready_q || i_read) begin
                data_d  = shreg_q;
                ready_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (ready_q && i_read) begin
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= RX_IDLE;
            cnt_q    <= '0;
            baud_q   <= '0;
            bitidx_q <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            baud_q   <= baud_d;
            bitidx_q <= bitidx_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_D       = data_q;
    assign o_ferr    = ferr_q;
    assign o_overrun = ovr_q;
endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port: stimulus pushes expected events into a
// scoreboard queue, a negedge monitor pops and compares as outputs change.
module tb_uart_rx_port;
    import uart_pkg::*;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [BAUD_W-1:0] i_baud;
    logic              i_rx;
    logic              i_read;
    logic              o_ready;
    logic [DATA_W-1:0] o_D;
    logic              o_ferr;
    logic              o_overrun;

    uart_rx_port dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_baud    (i_baud),
        .i_rx      (i_rx),
        .i_read    (i_read),
        .o_ready   (o_ready),
        .o_D       (o_D),
        .o_ferr    (o_ferr),
        .o_overrun (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    typedef enum int {EV_BYTE, EV_FERR, EV_OVR} ev_t;
    typedef struct {
        ev_t        kind;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_t k, input logic [7:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic take(input ev_t k, input logic [7:0] d);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got %s/0x%0h, want no event", k.name(), d);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.data !== d) begin
                n_err++;
                $display("FAIL sb_event: got %s/0x%0h, want %s/0x%0h",
                         k.name(), d, e.kind.name(), e.data);
            end
        end
    endtask

    // Monitor: new held byte, frame-error pulse cycles, overrun rising edge
    logic       prev_ready = 1'b0;
    logic       prev_ovr   = 1'b0;
    logic [7:0] prev_D     = '0;

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (o_ready === 1'b1 && (prev_ready !== 1'b1 || o_D !== prev_D)) take(EV_BYTE, o_D);
            if (o_ferr === 1'b1) take(EV_FERR, 8'h00);
            if (o_overrun === 1'b1 && prev_ovr !== 1'b1) take(EV_OVR, 8'h00);
        end
        prev_ready <= o_ready;
        prev_ovr   <= o_overrun;
        prev_D     <= o_D;
    end

    // Called right after a negedge; returns on a negedge.
    task automatic send_frame(input logic [7:0] b, input int baud, input logic stop);
        i_rx = 1'b0;
        repeat (baud) @(negedge i_clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (baud) @(negedge i_clk);
        end
        i_rx = stop;
        repeat (baud) @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic read_pulse();
        i_read = 1'b1;
        @(negedge i_clk);
        i_read = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, o_ready, 0);
        check({tag, "_D"}, o_D, 0);
        check({tag, "_ferr"}, o_ferr, 0);
        check({tag, "_ovr"}, o_overrun, 0);
    endtask

    initial begin
        i_rst  = 1'b1;
        i_rx   = 1'b1;
        i_read = 1'b0;
        i_baud = 16'd16;
        repeat (3) @(negedge i_clk);
        check_zero("reset");
        i_rst  = 1'b0;
        mon_en = 1'b1;
        @(negedge i_clk);

        // 0xA5 at baud 16: stop sampled at E154, o_ready visible after it
        expect_ev(EV_BYTE, 8'hA5);
        fork
            send_frame(8'hA5, 16, 1'b1);
            begin
                repeat (154) @(posedge i_clk);
                @(negedge i_clk);
                check("a5_ready_early", o_ready, 0);
                @(posedge i_clk);
                @(negedge i_clk);
                check("a5_ready", o_ready, 1);
                check("a5_D", o_D, 8'hA5);
                check("a5_ferr", o_ferr, 0);
                check("a5_ovr", o_overrun, 0);
            end
        join
        read_pulse();
        check("a5_read_clr", o_ready, 0);

        // Start glitch of 5 cycles is rejected, then 0x3C arrives
        idle(4);
        i_rx = 1'b0;
        repeat (5) @(negedge i_clk);
        idle(40);
        check("glitch_ready", o_ready, 0);
        expect_ev(EV_BYTE, 8'h3C);
        send_frame(8'h3C, 16, 1'b1);
        idle(4);
        check("3c_D", o_D, 8'h3C);
        read_pulse();

        // Frame error: one-cycle o_ferr, then a held-low line starts nothing
        expect_ev(EV_FERR, 8'h00);
        fork
            send_frame(8'h5A, 16, 1'b0);
            begin
                repeat (154) @(posedge i_clk);
                @(negedge i_clk);
                check("ferr_early", o_ferr, 0);
                @(posedge i_clk);
                @(negedge i_clk);
                check("ferr_pulse", o_ferr, 1);
                check("ferr_ready", o_ready, 0);
                @(posedge i_clk);
                @(negedge i_clk);
                check("ferr_late", o_ferr, 0);
            end
        join
        i_rx = 1'b0;
        repeat (40) @(negedge i_clk);
        check("break_ready", o_ready, 0);
        idle(20);
        expect_ev(EV_BYTE, 8'h81);
        send_frame(8'h81, 16, 1'b1);
        idle(4);
        check("81_D", o_D, 8'h81);
        read_pulse();

        // Back-to-back without reads: second byte lost, overrun sticks
        expect_ev(EV_BYTE, 8'h11);
        expect_ev(EV_OVR, 8'h00);
        send_frame(8'h11, 16, 1'b1);
        send_frame(8'h22, 16, 1'b1);
        idle(4);
        check("ovr_D", o_D, 8'h11);
        check("ovr_ready", o_ready, 1);
        check("ovr_flag", o_overrun, 1);
        read_pulse();
        check("ovr_read_ready", o_ready, 0);
        check("ovr_sticky", o_overrun, 1);

        // Read coincident with the second delivery (E314) keeps the new byte
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("rst2_ovr", o_overrun, 0);
        expect_ev(EV_BYTE, 8'h11);
        expect_ev(EV_BYTE, 8'h22);
        fork
            begin
                send_frame(8'h11, 16, 1'b1);
                send_frame(8'h22, 16, 1'b1);
            end
            begin
                repeat (314) @(posedge i_clk);
                @(negedge i_clk);
                i_read = 1'b1;
                @(posedge i_clk);
                @(negedge i_clk);
                i_read = 1'b0;
                check("rd_same_ready", o_ready, 1);
                check("rd_same_D", o_D, 8'h22);
            end
        join
        idle(4);
        check("rd_same_ovr", o_overrun, 0);
        read_pulse();

        // Reset during data bit 4 discards the frame
        fork
            begin
                i_rx = 1'b0;
                repeat (16) @(negedge i_clk);
                i_rx = 1'b1;
                repeat (100) @(negedge i_clk);
            end
            begin
                repeat (82) @(posedge i_clk);
                @(negedge i_clk);
                i_rst = 1'b1;
                @(negedge i_clk);
                i_rst = 1'b0;
                check_zero("midrst");
            end
        join

        // Odd baud 5
        i_baud = 16'd5;
        idle(10);
        expect_ev(EV_BYTE, 8'hF0);
        send_frame(8'hF0, 5, 1'b1);
        idle(4);
        check("f0_D", o_D, 8'hF0);
        check("f0_ready", o_ready, 1);
        read_pulse();

        // Divisor below MIN_BAUD is clamped to 4
        i_baud = 16'd1;
        idle(10);
        expect_ev(EV_BYTE, 8'h96);
        send_frame(8'h96, 4, 1'b1);
        idle(4);
        check("clamp_D", o_D, 8'h96);
        read_pulse();

        idle(10);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
